// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU control and M-extension sequencer:
// ALU control line encodings, ALUop classes, M funct3 codes, funct7 patterns
// and the sequencer state type.
package alu_pkg;

  // ALU control lines: arithmetic / logic
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1110;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  // ALU control lines: branch compares
  localparam logic [3:0] ALU_BEQ  = 4'b1100;
  localparam logic [3:0] ALU_BNE  = 4'b1101;
  localparam logic [3:0] ALU_BLT  = 4'b1000;
  localparam logic [3:0] ALU_BGE  = 4'b1001;
  localparam logic [3:0] ALU_BLTU = 4'b1010;
  localparam logic [3:0] ALU_BGEU = 4'b1011;

  // ALUop classes from the decoder
  localparam logic [1:0] ALUOP_ITYPE  = 2'b00;
  localparam logic [1:0] ALUOP_MEM    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_BRANCH = 2'b11;

  // M-extension funct3 codes
  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  // funct7 patterns
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/alu_ctrl_mdu_if.sv
// EX-stage bundle between the ID/EX register and the ALU control / MDU block.
// The pipeline side is the master; the control block is the slave.
interface alu_ctrl_mdu_if #(
  parameter int XLEN = 32
);
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            op_valid;
  logic            kill;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [3:0]      alu_lines;
  logic            alu_illegal;
  logic            mdu_stall;
  logic            mdu_done;
  logic [XLEN-1:0] mdu_result;

  modport master (
    output alu_op, funct3, funct7, op_valid, kill, rs1_val, rs2_val,
    input  alu_lines, alu_illegal, mdu_stall, mdu_done, mdu_result
  );

  modport slave (
    input  alu_op, funct3, funct7, op_valid, kill, rs1_val, rs2_val,
    output alu_lines, alu_illegal, mdu_stall, mdu_done, mdu_result
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-subtract step
// per cycle over XLEN cycles on magnitudes, with sign fix-up on the last step.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            last_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN);

  logic                run_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*XLEN-1:0]   acc_q;      // {hi, lo}: product, or {remainder, quotient}
  logic [XLEN-1:0]     opd_q;      // multiplicand or divisor magnitude
  logic [2:0]          op_q;
  logic                neg_res_q;  // negate product / quotient
  logic                neg_rem_q;  // negate remainder

  logic                sign_a;
  logic                sign_b;
  logic                a_neg;
  logic                b_neg;
  logic [XLEN-1:0]     mag_a;
  logic [XLEN-1:0]     mag_b;

  logic [XLEN-1:0]     hi;
  logic [XLEN-1:0]     lo;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift;
  logic [XLEN:0]       div_diff;
  logic                div_ge;
  logic [2*XLEN-1:0]   acc_next;
  logic [2*XLEN-1:0]   prod_fix;

  // Operand signedness by M operation
  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    case (op_i)
      M_MULH, M_DIV, M_REM: begin
        sign_a = 1'b1;
        sign_b = 1'b1;
      end
      M_MULHSU: sign_a = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = sign_a & rs1_i[XLEN-1];
  assign b_neg = sign_b & rs2_i[XLEN-1];
  assign mag_a = a_neg ? -rs1_i : rs1_i;
  assign mag_b = b_neg ? -rs2_i : rs2_i;

  assign hi = acc_q[2*XLEN-1:XLEN];
  assign lo = acc_q[XLEN-1:0];

  // Multiply: add the multiplicand when the low multiplier bit is set, shift right.
  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opd_q} : '0);

  // Divide: shift the next dividend bit into the remainder, keep the difference if it fits.
  assign div_shift = {hi, lo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opd_q};
  assign div_ge    = ~div_diff[XLEN];

  assign acc_next = op_q[2]
                  ? {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), lo[XLEN-2:0], div_ge}
                  : {mul_sum, lo[XLEN-1:1]};

  assign prod_fix = neg_res_q ? -acc_next : acc_next;

  // Sign-corrected result of the step being taken, used when it is the last one
  always_comb begin
    result_o = prod_fix[XLEN-1:0];
    case (op_q)
      M_MUL:                     result_o = prod_fix[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: result_o = prod_fix[2*XLEN-1:XLEN];
      M_DIV, M_DIVU:             result_o = neg_res_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
      M_REM, M_REMU:             result_o = neg_rem_q ? -acc_next[2*XLEN-1:XLEN]
                                                      : acc_next[2*XLEN-1:XLEN];
      default: ;
    endcase
  end

  assign last_o = run_q && (cnt_q == '0);

  // Operand latch at start, then one step per cycle until the count expires
  // NOTE: sequential state is assigned with <= so every register samples the pre-edge values of the others.
  // NOTE: the datapath registers are reset along with the control so the block powers up in a known, repeatable state.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q     <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opd_q     <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (kill_i) begin
      run_q <= 1'b0;
    end else if (start_i) begin
      run_q     <= 1'b1;
      cnt_q     <= CNT_W'(XLEN - 1);
      op_q      <= op_i;
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      if (op_i[2]) begin
        acc_q <= {{XLEN{1'b0}}, mag_a};
        opd_q <= mag_b;
      end else begin
        acc_q <= {{XLEN{1'b0}}, mag_b};
        opd_q <= mag_a;
      end
    end else if (run_q) begin
      acc_q <= acc_next;
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// Execute-stage control: ALUop/funct decode into ALU control lines, plus the
// RV32M/RV64M sequencer FSM with divide special cases and pipeline stall.
module alu_ctrl_mdu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  alu_ctrl_mdu_if.slave  ex_if
);

  mdu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            m_req;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_val;
  logic            iter_start;
  logic            iter_last;
  logic [XLEN-1:0] iter_result;
  logic [3:0]      lines;
  logic            illegal;
  logic            stall;
  logic            done;

  assign m_req = ex_if.op_valid && (ex_if.alu_op == ALUOP_RTYPE) && (ex_if.funct7 == F7_MULDIV);

  // Divide by zero and signed overflow finish without iterating.
  assign div_zero = ex_if.funct3[2] && (ex_if.rs2_val == '0);
  assign div_ovf  = ((ex_if.funct3 == M_DIV) || (ex_if.funct3 == M_REM))
                 && (ex_if.rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                 && (ex_if.rs2_val == '1);
  assign special  = div_zero || div_ovf;

  // funct3[1] separates remainder from quotient results
  assign special_val = div_zero ? (ex_if.funct3[1] ? ex_if.rs1_val : '1)
                                : (ex_if.funct3[1] ? '0 : ex_if.rs1_val);

  assign iter_start = (state_q == S_IDLE) && m_req && !ex_if.kill && !special;

  mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start_i  (iter_start),
    .kill_i   (ex_if.kill),
    .op_i     (ex_if.funct3),
    .rs1_i    (ex_if.rs1_val),
    .rs2_i    (ex_if.rs2_val),
    .last_o   (iter_last),
    .result_o (iter_result)
  );

  // ALU control line decode; an M request or undefined combination yields 0000
  always_comb begin
    lines   = ALU_ADD;
    illegal = 1'b0;
    if (!m_req) begin
      case (ex_if.alu_op)
        ALUOP_ITYPE: begin
          case (ex_if.funct3)
            3'b000: lines = ALU_ADD;
            3'b001: lines = ALU_SLL;
            3'b010: lines = ALU_SLT;
            3'b011: lines = ALU_SLTU;
            3'b100: lines = ALU_XOR;
            3'b101: lines = (ex_if.funct7[5] == F7_ALT[5]) ? ALU_SRA : ALU_SRL;
            3'b110: lines = ALU_OR;
            default: lines = ALU_AND;
          endcase
        end
        ALUOP_MEM: lines = ALU_ADD;
        ALUOP_RTYPE: begin
          case ({ex_if.funct3, ex_if.funct7[5]})
            4'b000_0: lines = ALU_ADD;
            4'b000_1: lines = ALU_SUB;
            4'b001_0: lines = ALU_SLL;
            4'b010_0: lines = ALU_SLT;
            4'b011_0: lines = ALU_SLTU;
            4'b100_0: lines = ALU_XOR;
            4'b101_0: lines = ALU_SRL;
            4'b101_1: lines = ALU_SRA;
            4'b110_0: lines = ALU_OR;
            4'b111_0: lines = ALU_AND;
            default:  illegal = 1'b1;
          endcase
        end
        default: begin
          case (ex_if.funct3)
            3'b000:  lines = ALU_BEQ;
            3'b001:  lines = ALU_BNE;
            3'b100:  lines = ALU_BLT;
            3'b101:  lines = ALU_BGE;
            3'b110:  lines = ALU_BLTU;
            3'b111:  lines = ALU_BGEU;
            default: illegal = 1'b1;
          endcase
        end
      endcase
    end
  end

  // Sequencer next state, result capture, stall and done
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    stall    = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (m_req && !ex_if.kill) begin
          stall = 1'b1;
          if (special) begin
            state_d  = S_DONE;
            result_d = special_val;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (ex_if.kill) begin
          state_d = S_IDLE;
        end else if (iter_last) begin
          state_d  = S_DONE;
          result_d = iter_result;
        end
      end
      S_DONE: begin
        // The instruction that was just served is still in EX; m_req is ignored here.
        done    = !ex_if.kill;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (ex_if.kill) begin
      stall = 1'b0;
    end
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  assign ex_if.alu_lines   = lines;
  assign ex_if.alu_illegal = illegal;
  assign ex_if.mdu_stall   = stall;
  assign ex_if.mdu_done    = done;
  assign ex_if.mdu_result  = result_q;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Self-checking bench for alu_ctrl_mdu at XLEN=32: decode sweep table, M-op
// vector table with a result scoreboard, and kill / reset sequences.
module tb_alu_ctrl_mdu;

  localparam int XLEN = 32;
  localparam int NORM_LAT = XLEN + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_ctrl_mdu_if #(.XLEN(XLEN)) ex ();

  alu_ctrl_mdu #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst   (rst),
    .ex_if (ex)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [XLEN-1:0] sb_q [$];

  typedef struct {
    logic [1:0] alu_op;
    logic [2:0] f3;
    logic       f7b5;
    logic [3:0] lines;
    logic       ill;
  } dec_vec_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } m_vec_t;

  localparam int N_M = 20;
  dec_vec_t dvec [64];
  m_vec_t   mvec [N_M];

  // Expected encodings written out from the ALU line table
  logic [3:0] i_tab [8]  = '{4'b0000, 4'b0010, 4'b1110, 4'b1111, 4'b0011, 4'b0100, 4'b0110, 4'b0111};
  logic [3:0] r_tab [16] = '{4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b1110, 4'b0000, 4'b1111, 4'b0000,
                             4'b0011, 4'b0000, 4'b0100, 4'b0101, 4'b0110, 4'b0000, 4'b0111, 4'b0000};
  logic       r_ill [16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                             1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [3:0] b_tab [8]  = '{4'b1100, 4'b1101, 4'b0000, 4'b0000, 4'b1000, 4'b1001, 4'b1010, 4'b1011};
  logic       b_ill [8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    ex.op_valid = 1'b0;
    ex.kill     = 1'b0;
    ex.alu_op   = 2'b00;
    ex.funct3   = 3'b000;
    ex.funct7   = 7'b0000000;
    ex.rs1_val  = '0;
    ex.rs2_val  = '0;
  endtask

  task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    ex.op_valid = 1'b1;
    ex.kill     = 1'b0;
    ex.alu_op   = 2'b10;
    ex.funct3   = f3;
    ex.funct7   = 7'b0000001;
    ex.rs1_val  = a;
    ex.rs2_val  = b;
  endtask

  // Issue one M instruction in the next cycle and hold it until mdu_done.
  task automatic run_m(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int lat);
    int          c;
    int          stalls;
    logic        got;
    logic        done_stall;
    logic [31:0] act;
    logic [31:0] exp;
    c = 0; stalls = 0; got = 1'b0; done_stall = 1'b1; act = '0;
    @(posedge clk); #1;
    drive_m(f3, a, b);
    sb_q.push_back(res);
    while (!got && c < 200) begin
      @(negedge clk);
      if (c == 0) begin
        check({name, " m_req lines"}, 64'(ex.alu_lines), 64'h0);
        check({name, " m_req illegal"}, 64'(ex.alu_illegal), 64'h0);
      end
      if (ex.mdu_done) begin
        got        = 1'b1;
        act        = ex.mdu_result;
        done_stall = ex.mdu_stall;
      end else begin
        if (ex.mdu_stall) stalls++;
        c++;
        @(posedge clk); #1;
      end
    end
    exp = sb_q.pop_front();
    check({name, " done cycle"}, 64'(c), 64'(lat));
    check({name, " stall cycles"}, 64'(stalls), 64'(lat));
    check({name, " stall in done"}, 64'(done_stall), 64'h0);
    check({name, " result"}, 64'(act), 64'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n_done;

    // Decode sweep table over alu_op x funct3 x funct7[5]
    for (int op = 0; op < 4; op++) begin
      for (int f = 0; f < 8; f++) begin
        for (int b = 0; b < 2; b++) begin
          int idx;
          idx = op * 16 + f * 2 + b;
          dvec[idx].alu_op = 2'(op);
          dvec[idx].f3     = 3'(f);
          dvec[idx].f7b5   = 1'(b);
          case (op)
            0: begin
              dvec[idx].lines = (f == 5 && b == 1) ? 4'b0101 : i_tab[f];
              dvec[idx].ill   = 1'b0;
            end
            1: begin
              dvec[idx].lines = 4'b0000;
              dvec[idx].ill   = 1'b0;
            end
            2: begin
              dvec[idx].lines = r_tab[f * 2 + b];
              dvec[idx].ill   = r_ill[f * 2 + b];
            end
            default: begin
              dvec[idx].lines = b_tab[f];
              dvec[idx].ill   = b_ill[f];
            end
          endcase
        end
      end
    end

    // M-op table: funct3, rs1, rs2, result, cycle of mdu_done
    mvec[0]  = '{3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, NORM_LAT};
    mvec[1]  = '{3'b000, 32'h0000_1234, 32'h0000_0100, 32'h0012_3400, NORM_LAT};
    mvec[2]  = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, NORM_LAT};
    mvec[3]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, NORM_LAT};
    mvec[4]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NORM_LAT};
    mvec[5]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, NORM_LAT};
    mvec[6]  = '{3'b011, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, NORM_LAT};
    mvec[7]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, NORM_LAT};
    mvec[8]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, NORM_LAT};
    mvec[9]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, NORM_LAT};
    mvec[10] = '{3'b101, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, NORM_LAT};
    mvec[11] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, NORM_LAT};
    mvec[12] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, NORM_LAT};
    mvec[13] = '{3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, NORM_LAT};
    mvec[14] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, NORM_LAT};
    mvec[15] = '{3'b100, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    mvec[16] = '{3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
    mvec[17] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    mvec[18] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    mvec[19] = '{3'b101, 32'h0000_0009, 32'h0000_0000, 32'hFFFF_FFFF, 1};

    // Reset state
    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset result", 64'(ex.mdu_result), 64'h0);
    check("reset done", 64'(ex.mdu_done), 64'h0);
    check("reset stall", 64'(ex.mdu_stall), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Decode sweep
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      ex.op_valid = 1'b1;
      ex.alu_op   = dvec[i].alu_op;
      ex.funct3   = dvec[i].f3;
      ex.funct7   = {1'b0, dvec[i].f7b5, 5'b00000};
      @(negedge clk);
      check($sformatf("decode op=%0d f3=%0d b5=%0d lines", dvec[i].alu_op, dvec[i].f3, dvec[i].f7b5),
            64'(ex.alu_lines), 64'(dvec[i].lines));
      check($sformatf("decode op=%0d f3=%0d b5=%0d illegal", dvec[i].alu_op, dvec[i].f3, dvec[i].f7b5),
            64'(ex.alu_illegal), 64'(dvec[i].ill));
      check($sformatf("decode op=%0d f3=%0d b5=%0d stall", dvec[i].alu_op, dvec[i].f3, dvec[i].f7b5),
            64'(ex.mdu_stall), 64'h0);
    end

    // M operations, issued back to back
    for (int i = 0; i < N_M; i++) begin
      run_m($sformatf("mvec%0d f3=%0d", i, mvec[i].f3), mvec[i].f3, mvec[i].a, mvec[i].b,
            mvec[i].res, mvec[i].lat);
    end
    @(posedge clk); #1;
    drive_idle();

    // Kill in BUSY cycle 10: no done pulse, then a normal MUL
    @(posedge clk); #1;
    drive_m(3'b000, 32'h0BAD_F00D, 32'h0000_1357);
    repeat (10) begin
      @(posedge clk); #1;
    end
    ex.kill = 1'b1;
    @(negedge clk);
    check("kill cycle stall", 64'(ex.mdu_stall), 64'h0);
    check("kill cycle done", 64'(ex.mdu_done), 64'h0);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("after kill stall", 64'(ex.mdu_stall), 64'h0);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (ex.mdu_done) n_done++;
    end
    check("after kill done pulses", 64'(n_done), 64'h0);
    run_m("mul 3x4 after kill", 3'b000, 32'd3, 32'd4, 32'd12, NORM_LAT);

    // Reset in the middle of BUSY
    @(posedge clk); #1;
    drive_m(3'b101, 32'hFFFF_FFFF, 32'h0000_0003);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    @(negedge clk);
    check("mid-busy reset result", 64'(ex.mdu_result), 64'h0);
    check("mid-busy reset done", 64'(ex.mdu_done), 64'h0);
    check("mid-busy reset stall", 64'(ex.mdu_stall), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (ex.mdu_done) n_done++;
    end
    check("after reset done pulses", 64'(n_done), 64'h0);
    run_m("remu after reset", 3'b111, 32'd100, 32'd7, 32'd2, NORM_LAT);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("done is one cycle", 64'(ex.mdu_done), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_mdu.md
# alu_ctrl_mdu

Execute-stage control block for the RISC-V core: decodes `ALUop`/`funct3`/`funct7` into the 4-bit ALU control lines, and adds RV32M/RV64M support through an iterative multiply/divide sequencer. The sequencer stalls the pipeline for multi-cycle operations and returns a registered result. It sits between the decoder/ID-EX register and the ALU/EX-MEM result mux, and is parametrised in datapath width.

## Interface
- `XLEN`, default 32: operand and result width; legal values are 32 and 64.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `alu_op`  in  2  00 = I-type ALU, 01 = load/store add, 10 = R-type, 11 = branch.
- `funct3`  in  3  instruction funct3.
- `funct7`  in  7  instruction funct7.
- `op_valid`  in  1  the EX stage holds a real instruction.
- `kill`  in  1  flush of the EX stage; aborts any M operation in flight.
- `rs1_val`  in  XLEN  operand A.
- `rs2_val`  in  XLEN  operand B.
- `alu_lines`  out  4  ALU control encoding; combinational.
- `alu_illegal`  out  1  the `alu_op`/`funct` combination is undefined; combinational.
- `mdu_stall`  out  1  hold IF/ID/EX; combinational.
- `mdu_done`  out  1  one-cycle pulse; `mdu_result` is valid in this cycle.
- `mdu_result`  out  XLEN  registered M-extension result.

## Operation
- **ALU line encoding:**
  - Arithmetic/logic: ADD 0000, SUB 0001, SLL 0010, XOR 0011, SRL 0100, SRA 0101, OR 0110, AND 0111, SLT 1110, SLTU 1111.
  - Branch: BEQ 1100, BNE 1101, BLT 1000, BGE 1001, BLTU 1010, BGEU 1011.
- **Per `alu_op`:**
  - `alu_op=00`: decode on `funct3`. For funct3=101, `funct7[5]` selects SRA (1) or SRL (0).
  - `alu_op=01`: always ADD.
  - `alu_op=10`: full R-type decode on {`funct3`, `funct7[5]`}.
  - `alu_op=11`: branch decode on `funct3`. Codes 010 and 011 are illegal.
- **Illegal combinations:** any undefined combination drives `alu_lines`=0000 with `alu_illegal`=1. The outputs never hold a stale value.
- **M detect:** `m_req` = `op_valid` & `alu_op`==10 & `funct7`==0000001. When `m_req` is true, `alu_lines`=0000 and `alu_illegal`=0.
- **M operations (by `funct3`):** 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- **FSM states:** IDLE, BUSY, DONE.
  - IDLE → BUSY on `m_req` & !`kill`. Operands and `funct3` are latched, `cnt` is set to XLEN−1, and `mdu_stall`=1.
  - IDLE → DONE directly, without entering BUSY, for these special cases:
    - Division by zero: DIV/DIVU give all ones; REM/REMU give `rs1_val`.
    - Signed overflow (DIV of −2^(XLEN−1) by −1): DIV gives −2^(XLEN−1); REM gives 0.
  - BUSY: performs one shift-add (multiply) or restoring-subtract (divide) step per cycle with `mdu_stall`=1. It goes to DONE when `cnt`==0; otherwise `cnt` decrements.
  - DONE: `mdu_done`=1 and `mdu_stall`=0, so the pipeline advances. It returns to IDLE unconditionally. `m_req` is ignored in DONE, because the same instruction is still present.
- **Arithmetic:**
  - Operands are converted to magnitudes according to signedness:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - All others: unsigned.
  - The product accumulator is 2·XLEN wide.
  - MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits.
  - Sign correction is applied on the final BUSY cycle:
    - Product negated if the operand signs differ.
    - Quotient negated if the operand signs differ.
    - Remainder takes the sign of the dividend.
- **`kill`:** in BUSY or DONE, the state becomes IDLE next cycle with no `mdu_done` pulse. In IDLE, `kill` suppresses the start. `mdu_stall` is forced to 0 while `kill`=1.

## Timing
- Reset values: state IDLE, `mdu_result`=0, `mdu_done`=0, `cnt`=0. `mdu_stall`=0 because `op_valid` is 0 after reset.
- Normal latency: detect in cycle 0, BUSY in cycles 1..XLEN, DONE in cycle XLEN+1. The stall lasts XLEN+1 cycles.
- Special-case latency: detect in cycle 0, DONE in cycle 1. The stall lasts 1 cycle.
- The pipeline must hold `alu_op`, `funct*`, `rs*_val` and `op_valid` stable while `mdu_stall`=1. The block latches operands only at detect.
- Back-to-back M instructions: the next instruction arrives in the cycle after DONE, with the state back in IDLE, and starts normally. There is no dead cycle beyond DONE.
- `rst` overrides `kill` and every state transition.

## Structure
- **Package `alu_pkg`:**
  - ALU line constants and `ALUop` codes.
  - M `funct3` constants.
  - `funct7` constants (0000000, 0100000, 0000001).
  - FSM state enum.
- **Sub-module `mdu_iter`:**
  - Holds the operand/accumulator registers, `cnt`, and the shift-add/subtract step.
  - Control inputs: start, op, kill.
  - Status outputs: last, result.
- **Top-level `alu_ctrl_mdu`:** holds the combinational decode, the FSM, special-case detection and stall generation.

## Test plan
- **Full decode sweep:** all `alu_op`×`funct3`×`funct7[5]` combinations with `funct7`≠0000001.
  - `alu_op=10`, `funct3=101`, `funct7[5]=1` → 0101.
  - `alu_op=11`, `funct3=010` → 0000 with `alu_illegal`=1.
- **MUL, XLEN=32:** MUL 0x0001_0000×0x0001_0000 → result 0, `mdu_done` in cycle 33, stall high in cycles 0–32.
- **Signed high products:**
  - MULH 0xFFFF_FFFF×0xFFFF_FFFF → 0.
  - MULHU with the same operands → 0xFFFF_FFFE.
  - MULHSU 0xFFFF_FFFF×2 → 0xFFFF_FFFF.
- **Signed divide:** DIV −7/2 → 0xFFFF_FFFD; REM −7/2 → 0xFFFF_FFFF; DIVU 7/2 → 3.
- **Special cases (done at cycle 1):**
  - DIV x/0 → 0xFFFF_FFFF; REMU 5/0 → 5.
  - DIV 0x8000_0000/−1 → 0x8000_0000; REM of the same operands → 0.
- **Kill and reset:**
  - `kill` in BUSY cycle 10 → IDLE next cycle, no done pulse; the following MUL 3×4 → 12.
  - `rst` mid-BUSY → all outputs at reset values next cycle.
